// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, 32x32 register file and ID/EX register.
// The write-back port writes the register file and forwards into same-cycle reads.
module decode_stage #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   valid_in,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  output logic                   valid_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [31:0]            rs1_data,
  output logic [31:0]            rs2_data,
  output logic [31:0]            imm,
  output logic [4:0]             rd,
  output logic [2:0]             funct3,
  output logic [3:0]             alu_op,
  output logic                   alu_src_imm,
  output logic                   reg_we,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic                   branch,
  output logic                   jump,
  output logic                   illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         rs1;
    logic [31:0]         rs2;
    logic [31:0]         imm;
    logic [4:0]          rd;
    logic [2:0]          f3;
    logic [3:0]          alu;
    logic                asi;
    logic                we;
    logic                mre;
    logic                mwe;
    logic                br;
    logic                jmp;
    logic                ill;
  } id_ex_t;

  logic [31:0] r_regs [32];
  id_ex_t      r_idex;
  id_ex_t      w_dec;

  logic [31:0] w_ins;
  logic [6:0]  w_opc;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  assign w_ins = instr_in[31:0];
  assign w_opc = w_ins[6:0];
  assign w_rs1 = w_ins[19:15];
  assign w_rs2 = w_ins[24:20];

  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25],
                    w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20],
                    w_ins[30:21], 1'b0};

  // x0 never forwards, so a write-back aimed at x0 cannot leak into a read
  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];

  function automatic logic [3:0] f_alu(input logic [2:0] f3,
                                       input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.pc    = pc_in;
    w_dec.rs1   = w_rs1_data;
    w_dec.rs2   = w_rs2_data;
    w_dec.rd    = w_ins[11:7];
    w_dec.f3    = w_ins[14:12];
    unique case (1'b1)
      w_opc == OP_R: begin
        w_dec.alu = f_alu(w_ins[14:12], w_ins[30]);
        w_dec.we  = 1'b1;
      end
      w_opc == OP_I: begin
        w_dec.alu = f_alu(w_ins[14:12],
                          (w_ins[14:12] == 3'b101) && w_ins[30]);
        w_dec.imm = w_imm_i;
        w_dec.asi = 1'b1;
        w_dec.we  = 1'b1;
      end
      w_opc == OP_LOAD: begin
        w_dec.imm = w_imm_i;
        w_dec.asi = 1'b1;
        w_dec.mre = 1'b1;
        w_dec.we  = 1'b1;
      end
      w_opc == OP_STORE: begin
        w_dec.imm = w_imm_s;
        w_dec.asi = 1'b1;
        w_dec.mwe = 1'b1;
      end
      w_opc == OP_BR: begin
        w_dec.alu = ALU_SUB;
        w_dec.imm = w_imm_b;
        w_dec.br  = 1'b1;
      end
      w_opc == OP_JAL: begin
        w_dec.imm = w_imm_j;
        w_dec.jmp = 1'b1;
        w_dec.we  = 1'b1;
      end
      w_opc == OP_JALR: begin
        w_dec.imm = w_imm_i;
        w_dec.asi = 1'b1;
        w_dec.jmp = 1'b1;
        w_dec.we  = 1'b1;
      end
      w_opc == OP_LUI: begin
        w_dec.alu = ALU_PASSB;
        w_dec.imm = w_imm_u;
        w_dec.asi = 1'b1;
        w_dec.we  = 1'b1;
      end
      w_opc == OP_AUIPC: begin
        w_dec.imm = w_imm_u;
        w_dec.asi = 1'b1;
        w_dec.we  = 1'b1;
      end
      default: begin
        w_dec.ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // flush outranks stall; a bubble on valid_in only lands when not stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (flush) begin
      r_idex <= '0;
    end else if (!stall) begin
      r_idex <= valid_in ? w_dec : '0;
    end
  end

  assign valid_out   = r_idex.valid;
  assign pc_out      = r_idex.pc;
  assign rs1_data    = r_idex.rs1;
  assign rs2_data    = r_idex.rs2;
  assign imm         = r_idex.imm;
  assign rd          = r_idex.rd;
  assign funct3      = r_idex.f3;
  assign alu_op      = r_idex.alu;
  assign alu_src_imm = r_idex.asi;
  assign reg_we      = r_idex.we;
  assign mem_re      = r_idex.mre;
  assign mem_we      = r_idex.mwe;
  assign branch      = r_idex.br;
  assign jump        = r_idex.jmp;
  assign illegal     = r_idex.ill;

endmodule
